// File: rtl/mcc_pkg.sv
// Shared state encodings, opcodes, select codes and control bundle for multicycle_ctrl.
// Optional jump support is enabled by MCCTRL_JUMP_EN.
package mcc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    localparam logic [STATE_W-1:0] ST_FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] ST_DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] ST_EXEC_R   = 4'd2;
    localparam logic [STATE_W-1:0] ST_WB_R     = 4'd3;
    localparam logic [STATE_W-1:0] ST_EXEC_I   = 4'd4;
    localparam logic [STATE_W-1:0] ST_WB_I     = 4'd5;
    localparam logic [STATE_W-1:0] ST_MEM_ADDR = 4'd6;
    localparam logic [STATE_W-1:0] ST_MEM_RD   = 4'd7;
    localparam logic [STATE_W-1:0] ST_MEM_WB   = 4'd8;
    localparam logic [STATE_W-1:0] ST_MEM_WR   = 4'd9;
    localparam logic [STATE_W-1:0] ST_BRANCH   = 4'd10;
    localparam logic [STATE_W-1:0] ST_JUMP     = 4'd11;
    localparam logic [STATE_W-1:0] ST_ILLEGAL  = 4'd12;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_EXEC_R   = ST_EXEC_R,
        S_WB_R     = ST_WB_R,
        S_EXEC_I   = ST_EXEC_I,
        S_WB_I     = ST_WB_I,
        S_MEM_ADDR = ST_MEM_ADDR,
        S_MEM_RD   = ST_MEM_RD,
        S_MEM_WB   = ST_MEM_WB,
        S_MEM_WR   = ST_MEM_WR,
        S_BRANCH   = ST_BRANCH,
        S_JUMP     = ST_JUMP,
        S_ILLEGAL  = ST_ILLEGAL
    } state_e;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [1:0] ASB_RT      = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Datapath control bundle; alu_op is carried separately because its width is a parameter.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mcc_out_decode.sv
// Combinational Moore output decode: state (+ op_q, mem_ready for FETCH writes) to datapath controls.
// JUMP state outputs exist only when MCCTRL_JUMP_EN is defined.
module mcc_out_decode
    import mcc_pkg::*;
#(
    parameter int unsigned            ALU_OP_W   = 3,
    parameter logic [ALU_OP_W-1:0]    ALU_OP_ADD = ALU_OP_W'(0),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_SUB = ALU_OP_W'(1),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_SLT = ALU_OP_W'(2),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_R   = ALU_OP_W'(4)
) (
    input  state_e              state_i,
    input  logic [OP_W-1:0]     op_i,
    input  logic                mem_ready_i,
    output ctrl_t               ctrl_o,
    output logic [ALU_OP_W-1:0] alu_op_o
);

    always_comb begin
        ctrl_o   = '0;
        alu_op_o = ALU_OP_ADD;
        case (state_i)
            S_FETCH: begin
                // IR and PC only update on the cycle the fetch read actually returns.
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ASB_FOUR;
                ctrl_o.pc_source = PCS_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                alu_op_o         = ALU_OP_ADD;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ASB_IMM_SH2;
                alu_op_o         = ALU_OP_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_RT;
                alu_op_o         = ALU_OP_R;
            end
            S_WB_R: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_IMM;
                alu_op_o         = (op_i == OP_SLTI) ? ALU_OP_SLT : ALU_OP_ADD;
            end
            S_WB_I: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ASB_IMM;
                alu_op_o         = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ASB_RT;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCS_ALUOUT;
                alu_op_o             = ALU_OP_SUB;
            end
`ifdef MCCTRL_JUMP_EN
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCS_JUMP;
            end
`endif
            S_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: begin
                ctrl_o   = '0;
                alu_op_o = ALU_OP_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle Moore control FSM with memory-ready stalls and illegal-opcode reporting.
// Define MCCTRL_JUMP_EN to add the J instruction (JUMP state); otherwise opcode 000010 is illegal.
module multicycle_ctrl
    import mcc_pkg::*;
#(
    parameter int unsigned            ALU_OP_W   = 3,
    parameter logic [ALU_OP_W-1:0]    ALU_OP_ADD = ALU_OP_W'(0),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_SUB = ALU_OP_W'(1),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_SLT = ALU_OP_W'(2),
    parameter logic [ALU_OP_W-1:0]    ALU_OP_R   = ALU_OP_W'(4)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                illegal_o,
    output logic [3:0]          state_o
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    ctrl_t               dec_ctrl_c, out_ctrl_c;
    logic [ALU_OP_W-1:0] dec_alu_op_c, out_alu_op_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state: DECODE branches on the live opcode (being latched), later states on op_q.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = instr_op_i;
                case (instr_op_i)
                    OP_R:            state_d = S_EXEC_R;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
`ifdef MCCTRL_JUMP_EN
                    OP_J:            state_d = S_JUMP;
`else
                    OP_J:            state_d = S_ILLEGAL;
`endif
                    default:         state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_BRANCH:   state_d = S_FETCH;
`ifdef MCCTRL_JUMP_EN
            S_JUMP:     state_d = S_FETCH;
`endif
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mcc_out_decode #(
        .ALU_OP_W   (ALU_OP_W),
        .ALU_OP_ADD (ALU_OP_ADD),
        .ALU_OP_SUB (ALU_OP_SUB),
        .ALU_OP_SLT (ALU_OP_SLT),
        .ALU_OP_R   (ALU_OP_R)
    ) u_out_decode (
        .state_i     (state_q),
        .op_i        (op_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (dec_ctrl_c),
        .alu_op_o    (dec_alu_op_c)
    );

    // Hold everything quiet while reset is asserted, even though FETCH would otherwise request a read.
    always_comb begin
        out_ctrl_c   = dec_ctrl_c;
        out_alu_op_c = dec_alu_op_c;
        if (rst_i) begin
            out_ctrl_c   = '0;
            out_alu_op_c = ALU_OP_ADD;
        end
    end

    assign pc_write_o      = out_ctrl_c.pc_write;
    assign pc_write_cond_o = out_ctrl_c.pc_write_cond;
    assign i_or_d_o        = out_ctrl_c.i_or_d;
    assign mem_read_o      = out_ctrl_c.mem_read;
    assign mem_write_o     = out_ctrl_c.mem_write;
    assign ir_write_o      = out_ctrl_c.ir_write;
    assign mem_to_reg_o    = out_ctrl_c.mem_to_reg;
    assign reg_write_o     = out_ctrl_c.reg_write;
    assign reg_dst_o       = out_ctrl_c.reg_dst;
    assign alu_src_a_o     = out_ctrl_c.alu_src_a;
    assign alu_src_b_o     = out_ctrl_c.alu_src_b;
    assign pc_source_o     = out_ctrl_c.pc_source;
    assign illegal_o       = out_ctrl_c.illegal;
    assign alu_op_o        = out_alu_op_c;
    assign state_o         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: expected state/ready per cycle queued, then drained and checked.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
    logic       ir_write_o, mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o;
    logic [1:0] alu_src_b_o, pc_source_o;
    logic [2:0] alu_op_o;
    logic       illegal_o;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int   exp_st_q[$];
    logic rdy_q[$];
    logic [17:0] obs_vec;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .instr_op_i      (instr_op_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .i_or_d_o        (i_or_d_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .reg_dst_o       (reg_dst_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .pc_source_o     (pc_source_o),
        .illegal_o       (illegal_o),
        .state_o         (state_o)
    );

    assign obs_vec = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
                      mem_to_reg_o, reg_write_o, reg_dst_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                      pc_source_o, illegal_o};

    // Expected control vector per state, written from the control table.
    function automatic logic [17:0] model(int st, logic [5:0] op, logic r);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, ill;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, ill} = '0;
        asb = 2'b00; ps = 2'b00; aop = 3'd0;
        case (st)
            0:  begin mr = 1'b1; asb = 2'b01; pw = r; irw = r; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; aop = 3'd4; end
            3:  begin rw = 1'b1; rd = 1'b1; end
            4:  begin asa = 1'b1; asb = 2'b10; aop = (op == 6'b001010) ? 3'd2 : 3'd0; end
            5:  rw = 1'b1;
            6:  begin asa = 1'b1; asb = 2'b10; end
            7:  begin mr = 1'b1; iod = 1'b1; end
            8:  begin rw = 1'b1; m2r = 1'b1; end
            9:  begin mw = 1'b1; iod = 1'b1; end
            10: begin asa = 1'b1; aop = 3'd1; pwc = 1'b1; ps = 2'b01; end
            11: begin pw = 1'b1; ps = 2'b10; end
            12: ill = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, asb, aop, ps, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input logic r);
        exp_st_q.push_back(st);
        rdy_q.push_back(r);
    endtask

    // Opcode is only valid in DECODE; elsewhere drive its complement so op_q use is exercised.
    task automatic drain(input string tag, input logic [5:0] op);
        int   st;
        logic r;
        while (exp_st_q.size() > 0) begin
            st = exp_st_q.pop_front();
            r  = rdy_q.pop_front();
            mem_ready_i = r;
            instr_op_i  = (st == 1) ? op : ~op;
            #2;
            check({tag, " state"}, 32'(state_o), 32'(st));
            check({tag, " outs"}, 32'(obs_vec), 32'(model(st, op, r)));
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        instr_op_i  = 6'b000000;
        #3;
        check("reset state", 32'(state_o), 32'd0);
        check("reset outs", 32'(obs_vec), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        push(0, 1'b0); push(0, 1'b0); push(0, 1'b1); push(1, 1'b1); push(2, 1'b1); push(3, 1'b1);
        drain("rtype", 6'b000000);

        push(0, 1'b1); push(1, 1'b1); push(6, 1'b1); push(7, 1'b0); push(7, 1'b0); push(7, 1'b1);
        push(8, 1'b1);
        drain("lw", 6'b100011);

        push(0, 1'b1); push(1, 1'b1); push(10, 1'b1);
        drain("beq", 6'b000100);

        push(0, 1'b1); push(1, 1'b1); push(4, 1'b1); push(5, 1'b1);
        drain("slti", 6'b001010);

        push(0, 1'b1); push(1, 1'b1); push(4, 1'b1); push(5, 1'b1);
        drain("addi", 6'b001000);

        push(0, 1'b1); push(1, 1'b1); push(6, 1'b1); push(9, 1'b1);
        drain("sw", 6'b101011);

        push(0, 1'b1); push(1, 1'b1); push(12, 1'b1);
        drain("illegal", 6'b111111);

        push(0, 1'b1); push(1, 1'b1);
`ifdef MCCTRL_JUMP_EN
        push(11, 1'b1);
`else
        push(12, 1'b1);
`endif
        drain("jump", 6'b000010);

        push(0, 1'b1); push(1, 1'b1); push(6, 1'b1); push(9, 1'b0);
        drain("sw stall", 6'b101011);

        mem_ready_i = 1'b0;
        #2;
        check("sw stall2 state", 32'(state_o), 32'd9);
        check("sw stall2 mem_write", 32'(mem_write_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("async rst mem_write", 32'(mem_write_o), 32'd0);
        check("async rst state", 32'(state_o), 32'd0);
        check("async rst outs", 32'(obs_vec), 32'd0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check("post rst ir_write", 32'(ir_write_o), 32'd1);
        check("post rst pc_write", 32'(pc_write_o), 32'd1);
        @(posedge clk_i);
        #1;
        push(1, 1'b1); push(2, 1'b1); push(3, 1'b1); push(0, 1'b1);
        drain("post rst rtype", 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
